sd_cmd_engine: RTL and testbench
================================

// Module: sd_cmd_engine
// PURPOSE
//  Builds SD SPI-mode command frames (CMD index + 32b arg + CRC7) and drives spi_controller:
//  one 6-byte write burst, then single-byte reads polling for the R1 response.
//  Sits directly upstream of spi_controller: serves its byte-address/data_in memory port,
//  issues start/op/size, consumes data_out/wr/done. Owns card chip-select.
// PARAMETERS
//  MEMORY_SIZE_IN_BYTES  64  must equal spi_controller's value; AW = $clog2(MEMORY_SIZE_IN_BYTES)
//  RESP_POLL_MAX         8   max R1 poll bytes before timeout (1..255)
// PORTS
//  clk            in   1   system clock; all state on posedge
//  rst_n          in   1   asynchronous active-low reset
//  cmd_valid      in   1   command request
//  cmd_ready      out  1   engine idle; request accepted when cmd_valid & cmd_ready
//  cmd_index      in   6   SD command number
//  cmd_arg        in   32  command argument
//  resp_valid     out  1   1-cycle pulse: command finished
//  resp_r1        out  8   R1 byte (8'hFF on timeout); held until next accept
//  resp_timeout   out  1   set with resp_valid if no R1 seen; held until next accept
//  cs_n           out  1   card chip-select, active low
//  spi_start      out  1   1-cycle start pulse to spi_controller
//  spi_op         out  1   1 = write, 0 = read; stable from start until spi_done
//  spi_size       out  AW  last byte index of burst (burst = size+1 bytes)
//  spi_address    in   AW  byte index requested by spi_controller
//  spi_data_in    out  8   frame[spi_address], combinational; 8'hFF for address >= 6
//  spi_data_out   in   8   received byte, valid when spi_wr = 1
//  spi_wr         in   1   received-byte strobe
//  spi_done       in   1   burst complete pulse
// BEHAVIOUR
//  Reset: state IDLE, cmd_ready=1, cs_n=1, spi_start=0, spi_op=0, spi_size=0, resp_valid=0,
//   resp_r1=8'hFF, resp_timeout=0, frame bytes=8'hFF, poll counter=0.
//  Frame: byte0={2'b01,cmd_index}, bytes1..4=cmd_arg MSB first, byte5={crc7,1'b1};
//   CRC7 poly x^7+x^3+1, init 0, over bytes0..4 MSB first.
//  FSM: IDLE -> CRC -> SEND -> WAIT_SEND -> POLL -> WAIT_POLL -> (POLL | FINISH) -> IDLE.
//   IDLE: on accept latch frame bytes0..4, clear crc, resp_timeout<=0, resp_r1<=8'hFF -> CRC.
//   CRC: one bit/cycle, exactly 40 cycles; byte5 written on last bit -> SEND.
//   SEND: cs_n<=0, spi_start=1, spi_op=1, spi_size=5 -> WAIT_SEND.
//   WAIT_SEND: hold outputs until spi_done -> POLL.
//   POLL: spi_start=1, spi_op=0, spi_size=0, poll counter+1 -> WAIT_POLL.
//   WAIT_POLL: on spi_wr capture byte; on spi_done: byte[7]==0 -> resp_r1<=byte, FINISH;
//    else counter==RESP_POLL_MAX -> resp_timeout<=1, resp_r1<=8'hFF, FINISH; else POLL.
//   FINISH: cs_n<=1, resp_valid=1 -> IDLE (cmd_ready=1 next cycle).
//  cmd_valid while busy ignored (not queued); cmd fields sampled only at accept.
//  spi_done/spi_wr outside WAIT_* ignored. spi_start never asserted again before spi_done.
//  Latency, CMD0 with R1 on nth poll: 1+40+1 + send burst + n*(1+poll burst) + 1 cycles.
//  Reset mid-operation: immediate return to reset values (cs_n=1, no resp_valid).
// STRUCTURE
//  sd_pkg: state enum, CMD_GO_IDLE=6'd0, CMD_SEND_IF_COND=6'd8, CMD_APP=6'd55,
//   ACMD_SD_SEND_OP_COND=6'd41, R1 bit masks (IDLE, ILLEGAL_CMD, CRC_ERR), FRAME_BYTES=6.
//  Sub-module sd_crc7: serial CRC7 (clr, en, bit_in -> crc[6:0]), reused by data path later.
// TESTING (bench pairs engine with spi_controller + MISO byte model)
//  CMD0 arg 0, MISO FF,FF,01 -> MOSI 40 00 00 00 00 95; 3 polls; resp_r1=01, timeout=0.
//  CMD8 arg 0x000001AA, MISO 01 -> MOSI 48 00 00 01 AA 87; resp_r1=01 after 1 poll.
//  CMD55 arg 0, MISO always FF, RESP_POLL_MAX=8 -> MOSI ends 65; 8 polls; timeout=1, r1=FF.
//  rst_n low during WAIT_SEND -> cs_n=1, cmd_ready=1 asynchronously, no resp_valid pulse.
//  cmd_valid held high two commands -> second accepted cycle after resp_valid; no overlap.
//  MISO 05 (illegal cmd) -> resp_r1=05; cs_n high exactly on resp_valid cycle.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD SPI-mode command path.
package sd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CRC,
      ST_SEND,
      ST_WAIT_SEND,
      ST_POLL,
      ST_WAIT_POLL,
      ST_FINISH
   } state_t;

   // Commonly used SD command indices
   localparam logic [5:0] CMD_GO_IDLE          = 6'd0;
   localparam logic [5:0] CMD_SEND_IF_COND     = 6'd8;
   localparam logic [5:0] CMD_APP              = 6'd55;
   localparam logic [5:0] ACMD_SD_SEND_OP_COND = 6'd41;

   // R1 response bit masks
   localparam logic [7:0] R1_IDLE        = 8'h01;
   localparam logic [7:0] R1_ILLEGAL_CMD = 8'h04;
   localparam logic [7:0] R1_CRC_ERR     = 8'h08;

   // Frame layout: index byte, four argument bytes, CRC byte
   localparam int FRAME_BYTES = 6;
   localparam int CRC_BITS    = 40;

   // x^7 + x^3 + 1 with the x^7 term implicit
   localparam logic [6:0] CRC7_POLY = 7'h09;

   // One serial CRC7 step, message bits fed MSB first
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
      logic fb;
      fb = bit_in ^ crc[6];
      return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
   endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 accumulator (one message bit per enabled cycle).
module sd_crc7
   import sd_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [6:0] crc
);

   // Clear has priority so a new message can start on the same cycle it is requested.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n)
         crc <= 7'h00;
      else if (clr)
         crc <= 7'h00;
      else if (en)
         crc <= crc7_step(crc, bit_in);
   end

endmodule

// File: rtl/sd_cmd_engine.sv
// Builds SD SPI-mode command frames and sequences spi_controller:
// one 6-byte write burst, then single-byte reads polling for R1.
module sd_cmd_engine
   import sd_pkg::*;
#(
   parameter  int MEMORY_SIZE_IN_BYTES = 64,
   parameter  int RESP_POLL_MAX        = 8,
   localparam int AW                   = $clog2(MEMORY_SIZE_IN_BYTES)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [5:0]    cmd_index,
   input  logic [31:0]   cmd_arg,
   output logic          resp_valid,
   output logic [7:0]    resp_r1,
   output logic          resp_timeout,
   output logic          cs_n,
   output logic          spi_start,
   output logic          spi_op,
   output logic [AW-1:0] spi_size,
   input  logic [AW-1:0] spi_address,
   output logic [7:0]    spi_data_in,
   input  logic [7:0]    spi_data_out,
   input  logic          spi_wr,
   input  logic          spi_done
);

   state_t     state;
   logic [7:0] frame [FRAME_BYTES];
   logic [5:0] bit_cnt;
   logic [7:0] poll_cnt;
   logic [7:0] rx_byte;
   logic [7:0] poll_byte;
   logic [6:0] crc;
   logic [6:0] crc_last;
   logic       crc_bit;
   logic       accept;

   assign accept    = cmd_valid & cmd_ready;
   assign crc_bit   = frame[bit_cnt[5:3]][3'd7 - bit_cnt[2:0]];
   // Look one step ahead so byte5 can be written on the cycle the last bit is consumed.
   assign crc_last  = crc7_step(crc, crc_bit);
   // A byte strobed on the same cycle as done must still be evaluated.
   assign poll_byte = spi_wr ? spi_data_out : rx_byte;

   sd_crc7 u_crc7 (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (accept),
      .en     (state == ST_CRC),
      .bit_in (crc_bit),
      .crc    (crc)
   );

   // Memory-port read: serve frame bytes, idle-high 0xFF beyond the frame.
   always_comb begin
      // NOTE: default first so every path assigns the output and no latch is inferred.
      spi_data_in = 8'hFF;
      for (int i = 0; i < FRAME_BYTES; i++)
         if (spi_address == AW'(i))
            spi_data_in = frame[i];
   end

   // Command sequencer; registered outputs are set on entry to the state that owns them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cmd_ready    <= 1'b1;
         cs_n         <= 1'b1;
         spi_start    <= 1'b0;
         spi_op       <= 1'b0;
         spi_size     <= '0;
         resp_valid   <= 1'b0;
         resp_r1      <= 8'hFF;
         resp_timeout <= 1'b0;
         bit_cnt      <= '0;
         poll_cnt     <= '0;
         rx_byte      <= 8'hFF;
         // NOTE: the frame is only six bytes, so it is reset like any register to keep
         // spi_data_in defined (0xFF) straight out of reset.
         for (int i = 0; i < FRAME_BYTES; i++)
            frame[i] <= 8'hFF;
      end else begin
         spi_start  <= 1'b0;
         resp_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (accept) begin
                  frame[0]     <= {2'b01, cmd_index};
                  frame[1]     <= cmd_arg[31:24];
                  frame[2]     <= cmd_arg[23:16];
                  frame[3]     <= cmd_arg[15:8];
                  frame[4]     <= cmd_arg[7:0];
                  resp_timeout <= 1'b0;
                  resp_r1      <= 8'hFF;
                  poll_cnt     <= '0;
                  bit_cnt      <= '0;
                  cmd_ready    <= 1'b0;
                  state        <= ST_CRC;
               end
            end
            ST_CRC: begin
               bit_cnt <= bit_cnt + 6'd1;
               if (bit_cnt == 6'(CRC_BITS - 1)) begin
                  frame[5]  <= {crc_last, 1'b1};
                  cs_n      <= 1'b0;
                  spi_start <= 1'b1;
                  spi_op    <= 1'b1;
                  spi_size  <= AW'(FRAME_BYTES - 1);
                  state     <= ST_SEND;
               end
            end
            ST_SEND: state <= ST_WAIT_SEND;
            ST_WAIT_SEND: begin
               if (spi_done) begin
                  spi_start <= 1'b1;
                  spi_op    <= 1'b0;
                  spi_size  <= '0;
                  poll_cnt  <= poll_cnt + 8'd1;
                  state     <= ST_POLL;
               end
            end
            ST_POLL: state <= ST_WAIT_POLL;
            ST_WAIT_POLL: begin
               if (spi_wr)
                  rx_byte <= spi_data_out;
               if (spi_done) begin
                  if (!poll_byte[7]) begin
                     resp_r1    <= poll_byte;
                     cs_n       <= 1'b1;
                     resp_valid <= 1'b1;
                     state      <= ST_FINISH;
                  end else if (poll_cnt == 8'(RESP_POLL_MAX)) begin
                     resp_timeout <= 1'b1;
                     resp_r1      <= 8'hFF;
                     cs_n         <= 1'b1;
                     resp_valid   <= 1'b1;
                     state        <= ST_FINISH;
                  end else begin
                     spi_start <= 1'b1;
                     poll_cnt  <= poll_cnt + 8'd1;
                     state     <= ST_POLL;
                  end
               end
            end
            ST_FINISH: begin
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_engine.sv
// Self-checking bench: behavioural spi_controller + MISO byte model around sd_cmd_engine.
module tb_sd_cmd_engine;
   import sd_pkg::*;

   localparam int MEM      = 64;
   localparam int AW       = $clog2(MEM);
   localparam int POLL_MAX = 8;

   logic          clk, rst_n;
   logic          cmd_valid, cmd_ready;
   logic [5:0]    cmd_index;
   logic [31:0]   cmd_arg;
   logic          resp_valid, resp_timeout, cs_n;
   logic [7:0]    resp_r1;
   logic          spi_start, spi_op;
   logic [AW-1:0] spi_size, spi_address;
   logic [7:0]    spi_data_in, spi_data_out;
   logic          spi_wr, spi_done;

   sd_cmd_engine #(.MEMORY_SIZE_IN_BYTES(MEM), .RESP_POLL_MAX(POLL_MAX)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_index(cmd_index), .cmd_arg(cmd_arg), .resp_valid(resp_valid),
      .resp_r1(resp_r1), .resp_timeout(resp_timeout), .cs_n(cs_n),
      .spi_start(spi_start), .spi_op(spi_op), .spi_size(spi_size),
      .spi_address(spi_address), .spi_data_in(spi_data_in),
      .spi_data_out(spi_data_out), .spi_wr(spi_wr), .spi_done(spi_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- spi_controller + card model ----------------
   logic [7:0] miso_q[$];
   logic [7:0] mosi_q[$];
   int rd_bursts = 0, wr_bursts = 0, overlap_err = 0, cs_err = 0;

   // Write burst: one byte per cycle; read burst: strobe byte, then done. Driven on negedges.
   initial begin
      spi_address  = '0;
      spi_data_out = 8'hFF;
      spi_wr       = 1'b0;
      spi_done     = 1'b0;
      forever begin
         if (spi_start !== 1'b1) @(negedge clk);
         else begin
            logic op;
            int   size;
            op   = spi_op;
            size = int'(spi_size);
            if (cs_n !== 1'b0) cs_err++;
            if (op) begin
               wr_bursts++;
               for (int i = 0; i <= size; i++) begin
                  spi_address = AW'(i);
                  #1 mosi_q.push_back(spi_data_in);
                  @(negedge clk);
                  if (spi_start === 1'b1 || spi_op !== op) overlap_err++;
               end
            end else begin
               rd_bursts++;
               @(negedge clk);
               if (spi_start === 1'b1 || spi_op !== op) overlap_err++;
               spi_wr       = 1'b1;
               spi_data_out = (miso_q.size() > 0) ? miso_q.pop_front() : 8'hFF;
               @(negedge clk);
               if (spi_start === 1'b1 || spi_op !== op) overlap_err++;
               spi_wr = 1'b0;
            end
            spi_done = 1'b1;
            @(negedge clk);
            spi_done = 1'b0;
         end
      end
   end

   // ---------------- reference model ----------------
   // Frame from the SD rules: CRC7 as polynomial remainder of msg*x^7 mod 0x89.
   function automatic logic [47:0] ref_frame(input logic [5:0] idx, input logic [31:0] arg);
      logic [46:0] r;
      r = {2'b01, idx, arg, 7'b0};
      for (int i = 46; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return {2'b01, idx, arg, r[6:0], 1'b1};
   endfunction

   task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg);
      logic [7:0]  list[$];
      logic [47:0] exp_frame, got_frame;
      logic [7:0]  exp_r1, b;
      logic        exp_to, prev_cs;
      int          exp_polls, lat, waited;
      list      = miso_q;
      exp_frame = ref_frame(idx, arg);
      exp_r1    = 8'hFF;
      exp_to    = 1'b1;
      exp_polls = POLL_MAX;
      for (int k = 0; k < POLL_MAX; k++) begin
         b = (k < list.size()) ? list[k] : 8'hFF;
         if (!b[7]) begin
            exp_r1 = b; exp_to = 1'b0; exp_polls = k + 1;
            break;
         end
      end
      mosi_q.delete();
      rd_bursts = 0;
      wr_bursts = 0;
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 500) begin @(negedge clk); waited++; end
      check({tag, " ready before"}, 64'(cmd_ready), 64'd1);
      cmd_valid = 1'b1; cmd_index = idx; cmd_arg = arg;
      @(negedge clk);
      lat = 2;
      cmd_valid = 1'b0; cmd_index = 6'($urandom); cmd_arg = $urandom;
      check({tag, " busy after accept"}, 64'(cmd_ready), 64'd0);
      prev_cs = cs_n;
      while (resp_valid !== 1'b1 && lat < 2000) begin
         prev_cs = cs_n;
         @(negedge clk);
         lat++;
      end
      check({tag, " resp_valid"}, 64'(resp_valid), 64'd1);
      // accept + 40 CRC + SEND + 6-cycle write burst + polls*(POLL + 2-cycle read) + FINISH
      check({tag, " latency"}, 64'(lat), 64'(1 + 40 + 1 + 6 + exp_polls * 3 + 1));
      check({tag, " r1"}, 64'(resp_r1), 64'(exp_r1));
      check({tag, " timeout"}, 64'(resp_timeout), 64'(exp_to));
      check({tag, " cs_n on resp"}, 64'(cs_n), 64'd1);
      check({tag, " cs_n before resp"}, 64'(prev_cs), 64'd0);
      check({tag, " mosi count"}, 64'(mosi_q.size()), 64'd6);
      got_frame = '0;
      foreach (mosi_q[i]) got_frame = {got_frame[39:0], mosi_q[i]};
      check({tag, " mosi frame"}, 64'(got_frame), 64'(exp_frame));
      check({tag, " polls"}, 64'(rd_bursts), 64'(exp_polls));
      check({tag, " writes"}, 64'(wr_bursts), 64'd1);
      @(negedge clk);
      check({tag, " resp pulse"}, 64'(resp_valid), 64'd0);
      check({tag, " ready after"}, 64'(cmd_ready), 64'd1);
      check({tag, " r1 held"}, 64'(resp_r1), 64'(exp_r1));
      check({tag, " protocol"}, 64'(overlap_err + cs_err), 64'd0);
      miso_q.delete();
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      int          seen, waited, nff;
      logic [47:0] got2;
      cmd_valid = 1'b0; cmd_index = '0; cmd_arg = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst cmd_ready", 64'(cmd_ready), 64'd1);
      check("rst cs_n", 64'(cs_n), 64'd1);
      check("rst outputs", 64'({spi_start, spi_op, resp_valid, resp_timeout}), 64'd0);
      check("rst spi_size", 64'(spi_size), 64'd0);
      check("rst resp_r1", 64'(resp_r1), 64'hFF);
      check("rst frame", 64'(spi_data_in), 64'hFF);
      rst_n = 1'b1;
      @(negedge clk);

      miso_q = '{8'hFF, 8'hFF, 8'h01};
      run_cmd("cmd0", CMD_GO_IDLE, 32'h0);
      miso_q = '{8'h01};
      run_cmd("cmd8", CMD_SEND_IF_COND, 32'h0000_01AA);
      run_cmd("cmd55 timeout", CMD_APP, 32'h0);
      miso_q = '{8'hFF, 8'h05};
      run_cmd("illegal", ACMD_SD_SEND_OP_COND, 32'h4000_0000);

      for (int t = 0; t < 6; t++) begin
         nff = $urandom_range(0, 9);
         for (int k = 0; k < nff; k++) miso_q.push_back(8'h80 | 8'($urandom));
         miso_q.push_back(8'($urandom_range(0, 127)));
         run_cmd($sformatf("rand%0d", t), 6'($urandom), $urandom);
      end

      // Reset while the write burst is in flight
      waited = 0;
      while (cmd_ready !== 1'b1 && waited < 500) begin @(negedge clk); waited++; end
      cmd_valid = 1'b1; cmd_index = CMD_APP; cmd_arg = $urandom;
      @(negedge clk);
      cmd_valid = 1'b0;
      waited = 0;
      while (spi_start !== 1'b1 && waited < 200) begin @(negedge clk); waited++; end
      check("mid rst reached send", 64'(spi_start), 64'd1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid rst cs_n", 64'(cs_n), 64'd1);
      check("mid rst cmd_ready", 64'(cmd_ready), 64'd1);
      check("mid rst resp_r1", 64'(resp_r1), 64'hFF);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (30) begin
         @(negedge clk);
         if (resp_valid === 1'b1) seen++;
      end
      check("mid rst no resp", 64'(seen), 64'd0);
      check("mid rst stays idle", 64'({cmd_ready, cs_n}), 64'b11);
      overlap_err = 0;
      cs_err = 0;
      miso_q.delete();

      // cmd_valid held across two commands
      miso_q = '{8'h01, 8'hFF, 8'h05};
      mosi_q.delete();
      rd_bursts = 0;
      cmd_valid = 1'b1; cmd_index = CMD_SEND_IF_COND; cmd_arg = 32'h0000_01AA;
      @(negedge clk);
      check("b2b first accepted", 64'(cmd_ready), 64'd0);
      cmd_index = ACMD_SD_SEND_OP_COND; cmd_arg = 32'h4000_0000;
      waited = 0;
      while (resp_valid !== 1'b1 && waited < 2000) begin @(negedge clk); waited++; end
      check("b2b resp1", 64'({resp_valid, resp_r1}), 64'h101);
      check("b2b busy on resp", 64'(cmd_ready), 64'd0);
      @(negedge clk);
      check("b2b ready after resp", 64'({cmd_ready, resp_valid}), 64'b10);
      @(negedge clk);
      check("b2b second accepted", 64'(cmd_ready), 64'd0);
      cmd_valid = 1'b0;
      waited = 0;
      while (resp_valid !== 1'b1 && waited < 2000) begin @(negedge clk); waited++; end
      check("b2b resp2", 64'({resp_valid, resp_timeout, resp_r1}), 64'h205);
      check("b2b mosi count", 64'(mosi_q.size()), 64'd12);
      got2 = '0;
      for (int i = 6; i < 12 && i < mosi_q.size(); i++) got2 = {got2[39:0], mosi_q[i]};
      check("b2b second frame", 64'(got2), 64'(ref_frame(ACMD_SD_SEND_OP_COND, 32'h4000_0000)));
      check("b2b polls", 64'(rd_bursts), 64'd3);
      check("b2b protocol", 64'(overlap_err + cs_err), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
